// File: rtl/pipe_controller.sv
// Control decode, pipelined control bundle and hazard/forwarding sequencer for the RVX10-P core.
// Latency: decode, hazard and forwarding outputs are combinational; control reaches EX/MEM/WB 1/2/3 edges after ID.
// Backpressure: a load-use hazard stalls F/D and bubbles EX for one cycle; a taken branch/jal squashes ID and EX.
module pipe_controller #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      Instr_D,
  input  logic             Zero_E,
  input  logic [4:0]       rs1_D,
  input  logic [4:0]       rs2_D,
  input  logic [4:0]       rs1_E,
  input  logic [4:0]       rs2_E,
  input  logic [4:0]       rd_E,
  input  logic [4:0]       rd_M,
  input  logic [4:0]       rd_W,
  output logic [1:0]       ImmSrc_D,
  output logic             ALUSrc_E,
  output logic [4:0]       ALUControl_E,
  output logic             PCSrc_E,
  output logic             MemWrite_M,
  output logic             RegWrite_W,
  output logic [1:0]       ResultSrc_W,
  output logic             stall_F,
  output logic             stall_D,
  output logic             flush_D,
  output logic             flush_E,
  output logic [1:0]       FwdSel_A,
  output logic [1:0]       FwdSel_B,
  output logic [CNT_W-1:0] InstRet,
  output logic             Illegal
);

  localparam logic [6:0] OP_LOAD    = 7'b0000011;
  localparam logic [6:0] OP_STORE   = 7'b0100011;
  localparam logic [6:0] OP_REG     = 7'b0110011;
  localparam logic [6:0] OP_IMM     = 7'b0010011;
  localparam logic [6:0] OP_BRANCH  = 7'b1100011;
  localparam logic [6:0] OP_JAL     = 7'b1101111;
  localparam logic [6:0] OP_CUSTOM0 = 7'b0001011;

  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b00001;
  localparam logic [4:0] ALU_AND = 5'b00010;
  localparam logic [4:0] ALU_OR  = 5'b00011;
  localparam logic [4:0] ALU_XOR = 5'b00100;
  localparam logic [4:0] ALU_SLT = 5'b00101;
  localparam logic [4:0] ALU_SLL = 5'b00110;
  localparam logic [4:0] ALU_SRL = 5'b00111;

  // Full bundle carried from ID into EX.
  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       alu_src;
    logic [4:0] alu_ctrl;
    logic       f3_lsb;
    logic       illegal;
    logic       valid;
  } ctrl_e_t;

  // Subset still needed once the instruction has left EX.
  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       valid;
  } ctrl_m_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       valid;
  } ctrl_w_t;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] base_op;
  logic       valid_d;
  logic       lw_stall;
  ctrl_e_t    dec;
  ctrl_e_t    ctrl_e_q;
  ctrl_m_t    ctrl_m_q;
  ctrl_w_t    ctrl_w_q;

  assign opcode = Instr_D[6:0];
  assign funct3 = Instr_D[14:12];
  assign funct7 = Instr_D[31:25];

  // funct3 to base ALU op, following the RV32I funct3 assignments (011 has no base op and falls back to ADD).
  always_comb begin
    base_op = ALU_ADD;
    case (funct3)
      3'b001:  base_op = ALU_SLL;
      3'b010:  base_op = ALU_SLT;
      3'b100:  base_op = ALU_XOR;
      3'b101:  base_op = ALU_SRL;
      3'b110:  base_op = ALU_OR;
      3'b111:  base_op = ALU_AND;
      default: base_op = ALU_ADD;
    endcase
  end

  // Instruction decode; bubbles (invalid slot or all-zero word) give an all-zero, legal bundle.
  always_comb begin
    dec      = '0;
    ImmSrc_D = 2'b00;
    if (valid_d && (Instr_D != 32'd0)) begin
      dec.valid = 1'b1;
      case (opcode)
        OP_LOAD: begin
          dec.reg_write  = 1'b1;
          dec.result_src = 2'b01;
          dec.alu_src    = 1'b1;
          dec.alu_ctrl   = ALU_ADD;
        end
        OP_STORE: begin
          dec.mem_write = 1'b1;
          dec.alu_src   = 1'b1;
          dec.alu_ctrl  = ALU_ADD;
          ImmSrc_D      = 2'b01;
        end
        OP_REG: begin
          dec.reg_write = 1'b1;
          dec.alu_ctrl  = ((funct3 == 3'b000) && funct7[5]) ? ALU_SUB : base_op;
        end
        OP_IMM: begin
          dec.reg_write = 1'b1;
          dec.alu_src   = 1'b1;
          dec.alu_ctrl  = base_op;
        end
        OP_BRANCH: begin
          dec.branch   = 1'b1;
          dec.alu_ctrl = ALU_SUB;
          dec.f3_lsb   = funct3[0];
          ImmSrc_D     = 2'b10;
        end
        OP_JAL: begin
          dec.jump       = 1'b1;
          dec.reg_write  = 1'b1;
          dec.result_src = 2'b10;
          ImmSrc_D       = 2'b11;
        end
        OP_CUSTOM0: begin
          if (funct7 == 7'b0000000) begin
            dec.reg_write = 1'b1;
            dec.alu_ctrl  = {2'b01, funct3};
          end else if (funct7 == 7'b0000001) begin
            dec.reg_write = 1'b1;
            dec.alu_ctrl  = {2'b10, funct3};
          end else begin
            dec.illegal = 1'b1;
          end
        end
        default: dec.illegal = 1'b1;
      endcase
    end
  end

  // Redirect, load-use detection and the resulting stall/flush controls; redirect beats stall.
  always_comb begin
    PCSrc_E  = ctrl_e_q.valid &
               (ctrl_e_q.jump | (ctrl_e_q.branch & (Zero_E ^ ctrl_e_q.f3_lsb)));
    lw_stall = (ctrl_e_q.result_src == 2'b01) && (rd_E != 5'd0) &&
               ((rd_E == rs1_D) || (rd_E == rs2_D));
    stall_F  = lw_stall & ~PCSrc_E;
    stall_D  = lw_stall & ~PCSrc_E;
    flush_E  = lw_stall | PCSrc_E;
    flush_D  = PCSrc_E;
  end

  // Operand forwarding; the younger MEM result wins over WB.
  always_comb begin
    FwdSel_A = 2'b00;
    FwdSel_B = 2'b00;
    if (ctrl_m_q.reg_write && (rd_M != 5'd0) && (rd_M == rs1_E))      FwdSel_A = 2'b10;
    else if (ctrl_w_q.reg_write && (rd_W != 5'd0) && (rd_W == rs1_E)) FwdSel_A = 2'b01;
    if (ctrl_m_q.reg_write && (rd_M != 5'd0) && (rd_M == rs2_E))      FwdSel_B = 2'b10;
    else if (ctrl_w_q.reg_write && (rd_W != 5'd0) && (rd_W == rs2_E)) FwdSel_B = 2'b01;
  end

  // Stage control registers, ID valid bit, retire counter and sticky illegal flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_d  <= 1'b0;
      ctrl_e_q <= '0;
      ctrl_m_q <= '0;
      ctrl_w_q <= '0;
      InstRet  <= '0;
      Illegal  <= 1'b0;
    end else begin
      if (flush_D)       valid_d <= 1'b0;
      else if (!stall_D) valid_d <= 1'b1;
      ctrl_e_q <= flush_E ? '0 : dec;
      ctrl_m_q.reg_write  <= ctrl_e_q.reg_write;
      ctrl_m_q.result_src <= ctrl_e_q.result_src;
      ctrl_m_q.mem_write  <= ctrl_e_q.mem_write;
      ctrl_m_q.valid      <= ctrl_e_q.valid;
      ctrl_w_q.reg_write  <= ctrl_m_q.reg_write;
      ctrl_w_q.result_src <= ctrl_m_q.result_src;
      ctrl_w_q.valid      <= ctrl_m_q.valid;
      if (ctrl_w_q.valid) InstRet <= InstRet + CNT_W'(1);
      if (ctrl_e_q.valid && ctrl_e_q.illegal) Illegal <= 1'b1;
    end
  end

  assign ALUSrc_E     = ctrl_e_q.alu_src;
  assign ALUControl_E = ctrl_e_q.alu_ctrl;
  assign MemWrite_M   = ctrl_m_q.mem_write;
  assign RegWrite_W   = ctrl_w_q.reg_write;
  assign ResultSrc_W  = ctrl_w_q.result_src;

endmodule

// File: tb/tb_pipe_controller.sv
// Bench for pipe_controller: table of single-instruction decodes, hand sequences for hazards, and a random run against a model.
// Latency: checks sample 1 time unit after inputs change, which is itself 1 unit after each rising edge.
// Backpressure: none; the bench drives the rs/rd address inputs directly as the datapath would.
module tb_pipe_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Instr_D;
  logic        Zero_E;
  logic [4:0]  rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
  logic [1:0]  ImmSrc_D, ResultSrc_W, FwdSel_A, FwdSel_B;
  logic        ALUSrc_E, PCSrc_E, MemWrite_M, RegWrite_W, Illegal;
  logic        stall_F, stall_D, flush_D, flush_E;
  logic [4:0]  ALUControl_E;
  logic [31:0] InstRet;
  // narrow-counter instance, used for the wrap check
  logic [1:0]  s_ImmSrc, s_ResultSrc, s_FwdA, s_FwdB;
  logic        s_ALUSrc, s_PCSrc, s_MemWrite, s_RegWrite, s_Illegal;
  logic        s_stall_F, s_stall_D, s_flush_D, s_flush_E;
  logic [4:0]  s_ALUControl;
  logic [2:0]  s_InstRet;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipe_controller #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .Instr_D(Instr_D), .Zero_E(Zero_E),
    .rs1_D(rs1_D), .rs2_D(rs2_D), .rs1_E(rs1_E), .rs2_E(rs2_E),
    .rd_E(rd_E), .rd_M(rd_M), .rd_W(rd_W),
    .ImmSrc_D(ImmSrc_D), .ALUSrc_E(ALUSrc_E), .ALUControl_E(ALUControl_E),
    .PCSrc_E(PCSrc_E), .MemWrite_M(MemWrite_M), .RegWrite_W(RegWrite_W),
    .ResultSrc_W(ResultSrc_W), .stall_F(stall_F), .stall_D(stall_D),
    .flush_D(flush_D), .flush_E(flush_E), .FwdSel_A(FwdSel_A), .FwdSel_B(FwdSel_B),
    .InstRet(InstRet), .Illegal(Illegal)
  );

  pipe_controller #(.CNT_W(3)) dut_small (
    .clk(clk), .reset(reset), .Instr_D(Instr_D), .Zero_E(Zero_E),
    .rs1_D(rs1_D), .rs2_D(rs2_D), .rs1_E(rs1_E), .rs2_E(rs2_E),
    .rd_E(rd_E), .rd_M(rd_M), .rd_W(rd_W),
    .ImmSrc_D(s_ImmSrc), .ALUSrc_E(s_ALUSrc), .ALUControl_E(s_ALUControl),
    .PCSrc_E(s_PCSrc), .MemWrite_M(s_MemWrite), .RegWrite_W(s_RegWrite),
    .ResultSrc_W(s_ResultSrc), .stall_F(s_stall_F), .stall_D(s_stall_D),
    .flush_D(s_flush_D), .flush_E(s_flush_E), .FwdSel_A(s_FwdA), .FwdSel_B(s_FwdB),
    .InstRet(s_InstRet), .Illegal(s_Illegal)
  );

  logic [21:0] dut_vec;
  assign dut_vec = {ImmSrc_D, ALUSrc_E, ALUControl_E, PCSrc_E, MemWrite_M, RegWrite_W,
                    ResultSrc_W, stall_F, stall_D, flush_D, flush_E, FwdSel_A, FwdSel_B, Illegal};

  // ---------------- reference model ----------------
  typedef struct packed {
    logic       rw;
    logic [1:0] rsrc;
    logic       mw;
    logic       br;
    logic       jp;
    logic       als;
    logic [4:0] alu;
    logic       f30;
    logic       ill;
    logic       v;
    logic [1:0] imm;
  } rec_t;

  // funct3 -> base op: add, sll, slt, (none->add), xor, srl, or, and
  localparam logic [4:0] F3_OP [8] = '{5'd0, 5'd6, 5'd5, 5'd0, 5'd4, 5'd7, 5'd3, 5'd2};

  bit          m_vd;
  rec_t        m_e, m_m, m_w;
  logic [31:0] m_cnt;
  bit          m_ill;

  function automatic rec_t model_decode(input logic [31:0] ins, input bit vd);
    rec_t r = '0;
    logic [6:0] op = ins[6:0];
    logic [2:0] f3 = ins[14:12];
    logic [6:0] f7 = ins[31:25];
    if (!vd || ins == 32'd0) return r;
    r.v = 1'b1;
    if (op == 7'b0000011) begin r.rw = 1; r.rsrc = 2'b01; r.als = 1; end
    else if (op == 7'b0100011) begin r.mw = 1; r.als = 1; r.imm = 2'b01; end
    else if (op == 7'b0110011) begin r.rw = 1; r.alu = (f3 == 0 && f7[5]) ? 5'd1 : F3_OP[f3]; end
    else if (op == 7'b0010011) begin r.rw = 1; r.als = 1; r.alu = F3_OP[f3]; end
    else if (op == 7'b1100011) begin r.br = 1; r.imm = 2'b10; r.alu = 5'd1; r.f30 = f3[0]; end
    else if (op == 7'b1101111) begin r.jp = 1; r.rw = 1; r.rsrc = 2'b10; r.imm = 2'b11; end
    else if (op == 7'b0001011) begin
      if (f7 == 7'd0)      begin r.rw = 1; r.alu = 5'd8  + 5'(f3); end
      else if (f7 == 7'd1) begin r.rw = 1; r.alu = 5'd16 + 5'(f3); end
      else r.ill = 1;
    end
    else r.ill = 1;
    return r;
  endfunction

  function automatic logic [1:0] model_fwd(input logic [4:0] rs);
    if (m_m.rw && rd_M != 0 && rd_M == rs) return 2'b10;
    if (m_w.rw && rd_W != 0 && rd_W == rs) return 2'b01;
    return 2'b00;
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, wanted %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [4:0] r1d, input logic [4:0] r2d,
                       input logic [4:0] r1e, input logic [4:0] r2e,
                       input logic [4:0] rde, input logic [4:0] rdm, input logic [4:0] rdw,
                       input logic z);
    Instr_D = ins; rs1_D = r1d; rs2_D = r2d; rs1_E = r1e; rs2_E = r2e;
    rd_E = rde; rd_M = rdm; rd_W = rdw; Zero_E = z;
    #1;
  endtask

  task automatic idle(input logic [31:0] ins);
    drive(ins, 0, 0, 0, 0, 0, 0, 0, 1'b0);
  endtask

  // reset, then one quiet edge so the ID slot is valid
  task automatic do_reset();
    reset = 1'b1;
    idle(32'd0);
    tick();
    reset = 1'b0;
    tick();
  endtask

  typedef struct {
    logic [31:0] ins;
    logic [1:0]  imm;
    logic        als;
    logic [4:0]  alu;
    logic        pc;
    logic        ill;
  } vec_t;

  localparam logic [31:0] ADDI_X1   = 32'h00500093;
  localparam logic [31:0] ADD_X2    = 32'h00108133;
  localparam logic [31:0] LW_X3     = 32'h00002183;
  localparam logic [31:0] ADD_X4    = 32'h00018233;
  localparam logic [31:0] SW_X1     = 32'h00102023;
  localparam logic [31:0] BEQ       = 32'h00000063;
  localparam logic [31:0] BNE       = 32'h00001063;
  localparam logic [31:0] RVX_10010 = 32'h0220A18B;
  localparam logic [31:0] RVX_BAD   = 32'h0600000B;

  localparam logic [31:0] POOL [12] = '{ADDI_X1, ADD_X2, LW_X3, ADD_X4, SW_X1, BEQ, BNE,
                                        32'h000000EF, RVX_10010, RVX_BAD, 32'h0000007F, 32'd0};

  vec_t tbl [20];

  initial begin
    reset = 1'b0;
    idle(32'd0);

    tbl[0]  = '{ADDI_X1,      2'b00, 1'b1, 5'b00000, 1'b0, 1'b0};
    tbl[1]  = '{ADD_X2,       2'b00, 1'b0, 5'b00000, 1'b0, 1'b0};
    tbl[2]  = '{32'h403100B3, 2'b00, 1'b0, 5'b00001, 1'b0, 1'b0};
    tbl[3]  = '{32'h40000013, 2'b00, 1'b1, 5'b00000, 1'b0, 1'b0};
    tbl[4]  = '{32'h00004013, 2'b00, 1'b1, 5'b00100, 1'b0, 1'b0};
    tbl[5]  = '{32'h00006013, 2'b00, 1'b1, 5'b00011, 1'b0, 1'b0};
    tbl[6]  = '{32'h00007013, 2'b00, 1'b1, 5'b00010, 1'b0, 1'b0};
    tbl[7]  = '{32'h00001013, 2'b00, 1'b1, 5'b00110, 1'b0, 1'b0};
    tbl[8]  = '{32'h00005013, 2'b00, 1'b1, 5'b00111, 1'b0, 1'b0};
    tbl[9]  = '{32'h00002013, 2'b00, 1'b1, 5'b00101, 1'b0, 1'b0};
    tbl[10] = '{LW_X3,        2'b00, 1'b1, 5'b00000, 1'b0, 1'b0};
    tbl[11] = '{SW_X1,        2'b01, 1'b1, 5'b00000, 1'b0, 1'b0};
    tbl[12] = '{BEQ,          2'b10, 1'b0, 5'b00001, 1'b0, 1'b0};
    tbl[13] = '{BNE,          2'b10, 1'b0, 5'b00001, 1'b1, 1'b0};
    tbl[14] = '{32'h000000EF, 2'b11, 1'b0, 5'b00000, 1'b1, 1'b0};
    tbl[15] = '{RVX_10010,    2'b00, 1'b0, 5'b10010, 1'b0, 1'b0};
    tbl[16] = '{32'h0000500B, 2'b00, 1'b0, 5'b01101, 1'b0, 1'b0};
    tbl[17] = '{RVX_BAD,      2'b00, 1'b0, 5'b00000, 1'b0, 1'b1};
    tbl[18] = '{32'h0000007F, 2'b00, 1'b0, 5'b00000, 1'b0, 1'b1};
    tbl[19] = '{32'd0,        2'b00, 1'b0, 5'b00000, 1'b0, 1'b0};

    // reset state
    reset = 1'b1;
    idle(ADDI_X1);
    tick();
    check("reset_outputs", 32'(dut_vec), 32'd0);
    check("reset_instret", InstRet, 32'd0);
    reset = 1'b0;

    // single-instruction decode table (Zero_E=0, no hazards)
    foreach (tbl[i]) begin
      do_reset();
      idle(tbl[i].ins);
      check($sformatf("tbl%0d_imm", i), 32'(ImmSrc_D), 32'(tbl[i].imm));
      tick();
      idle(32'd0);
      check($sformatf("tbl%0d_als", i), 32'(ALUSrc_E), 32'(tbl[i].als));
      check($sformatf("tbl%0d_alu", i), 32'(ALUControl_E), 32'(tbl[i].alu));
      check($sformatf("tbl%0d_pc", i), 32'(PCSrc_E), 32'(tbl[i].pc));
      tick();
      check($sformatf("tbl%0d_ill", i), 32'(Illegal), 32'(tbl[i].ill));
    end

    // addi retires: in WB after 3 edges, counted on the 4th
    do_reset();
    idle(ADDI_X1);
    tick(); idle(32'd0); tick(); tick();
    check("addi_regwrite_w", 32'(RegWrite_W), 32'd1);
    check("addi_resultsrc_w", 32'(ResultSrc_W), 32'd0);
    check("addi_instret_before", InstRet, 32'd0);
    tick();
    check("addi_instret", InstRet, 32'd1);

    // forwarding: MEM, WB, x0 producer, MEM-over-WB priority
    do_reset();
    idle(ADDI_X1); tick();
    idle(ADD_X2); tick();
    drive(32'd0, 0, 0, 1, 1, 2, 1, 0, 1'b0);
    check("fwd_mem_a", 32'(FwdSel_A), 32'd2);
    check("fwd_mem_b", 32'(FwdSel_B), 32'd2);
    tick();
    drive(32'd0, 0, 0, 1, 1, 0, 2, 1, 1'b0);
    check("fwd_wb_a", 32'(FwdSel_A), 32'd1);
    check("fwd_wb_b", 32'(FwdSel_B), 32'd1);
    drive(32'd0, 0, 0, 0, 0, 0, 2, 0, 1'b0);
    check("fwd_x0", 32'({FwdSel_A, FwdSel_B}), 32'd0);
    drive(32'd0, 0, 0, 1, 2, 0, 1, 1, 1'b0);
    check("fwd_prio_a", 32'(FwdSel_A), 32'd2);
    check("fwd_b_none", 32'(FwdSel_B), 32'd0);

    // load-use: one bubble, then WB forwarding
    do_reset();
    idle(LW_X3); tick();
    drive(ADD_X4, 3, 0, 0, 0, 3, 0, 0, 1'b0);
    check("lu_stall", 32'({stall_F, stall_D, flush_E, flush_D}), 32'b1110);
    tick();
    drive(ADD_X4, 3, 0, 0, 0, 0, 3, 0, 1'b0);
    check("lu_release", 32'({stall_F, stall_D, flush_E, flush_D}), 32'b0000);
    tick();
    drive(32'd0, 0, 0, 3, 0, 4, 0, 3, 1'b0);
    check("lu_fwd_a", 32'(FwdSel_A), 32'd1);
    check("lu_load_in_wb", 32'({RegWrite_W, ResultSrc_W}), 32'b101);
    tick(); idle(32'd0); tick(); tick(); tick();
    check("lu_instret", InstRet, 32'd2);

    // taken beq squashes two, bne with Zero_E=1 falls through
    do_reset();
    idle(BEQ); tick();
    drive(ADDI_X1, 0, 0, 0, 0, 0, 0, 0, 1'b1);
    check("beq_taken", 32'({PCSrc_E, flush_D, flush_E, stall_F}), 32'b1110);
    tick();
    idle(ADDI_X1);
    check("beq_after", 32'({PCSrc_E, flush_D, flush_E, ALUControl_E}), 32'd0);
    tick(); idle(32'd0);
    for (int k = 0; k < 5; k++) tick();
    check("beq_instret", InstRet, 32'd1);
    do_reset();
    idle(BNE); tick();
    drive(32'd0, 0, 0, 0, 0, 0, 0, 0, 1'b1);
    check("bne_zero", 32'(PCSrc_E), 32'd0);

    // illegal RVX10 funct7: zero control, sticky until reset
    do_reset();
    idle(RVX_BAD); tick(); idle(32'd0);
    check("ill_ctl", 32'({ALUSrc_E, ALUControl_E, PCSrc_E}), 32'd0);
    check("ill_not_yet", 32'(Illegal), 32'd0);
    tick(); tick(); tick();
    check("ill_sticky", 32'(Illegal), 32'd1);
    do_reset();
    check("ill_cleared", 32'(Illegal), 32'd0);

    // reset mid-flight with sw in MEM
    do_reset();
    idle(ADDI_X1); tick();
    idle(SW_X1); tick();
    idle(32'd0); tick();
    check("sw_in_mem", 32'(MemWrite_M), 32'd1);
    reset = 1'b1;
    tick();
    check("midreset_outputs", 32'(dut_vec), 32'd0);
    check("midreset_instret", InstRet, 32'd0);
    reset = 1'b0;

    // counter wrap on the narrow instance
    do_reset();
    for (int k = 0; k < 9; k++) begin idle(ADDI_X1); tick(); end
    idle(32'd0);
    for (int k = 0; k < 5; k++) tick();
    check("wrap_wide", InstRet, 32'd9);
    check("wrap_narrow", 32'(s_InstRet), 32'd1);

    // random run against the model
    do_reset();
    m_vd = 1'b1; m_e = '0; m_m = '0; m_w = '0; m_cnt = '0; m_ill = 1'b0;
    for (int i = 0; i < 800; i++) begin
      rec_t        d;
      logic        taken, load_dep, hold;
      logic [21:0] exp;
      reset   = ($urandom_range(0, 59) == 0);
      Instr_D = ($urandom_range(0, 5) == 0) ? $urandom : POOL[$urandom_range(0, 11)];
      Zero_E  = 1'($urandom_range(0, 1));
      rs1_D = 5'($urandom_range(0, 3)); rs2_D = 5'($urandom_range(0, 3));
      rs1_E = 5'($urandom_range(0, 3)); rs2_E = 5'($urandom_range(0, 3));
      rd_E  = 5'($urandom_range(0, 3)); rd_M  = 5'($urandom_range(0, 3));
      rd_W  = 5'($urandom_range(0, 3));
      #1;
      d        = model_decode(Instr_D, m_vd);
      taken    = m_e.v && (m_e.jp || (m_e.br && (Zero_E != m_e.f30)));
      load_dep = (m_e.rsrc == 2'b01) && rd_E != 0 && (rd_E == rs1_D || rd_E == rs2_D);
      hold     = load_dep && !taken;
      exp = {d.imm, m_e.als, m_e.alu, taken, m_m.mw, m_w.rw, m_w.rsrc,
             hold, hold, taken, load_dep || taken, model_fwd(rs1_E), model_fwd(rs2_E), m_ill};
      check($sformatf("rand_ctl@%0d", i), 32'(dut_vec), 32'(exp));
      check($sformatf("rand_cnt@%0d", i), InstRet, m_cnt);
      check($sformatf("rand_cnt3@%0d", i), 32'(s_InstRet), 32'(m_cnt[2:0]));
      if (reset) begin
        m_vd = 1'b0; m_e = '0; m_m = '0; m_w = '0; m_cnt = '0; m_ill = 1'b0;
      end else begin
        m_cnt = m_cnt + 32'(m_w.v);
        m_ill = m_ill | (m_e.v & m_e.ill);
        m_w   = m_m;
        m_m   = m_e;
        m_e   = (load_dep || taken) ? '0 : d;
        m_vd  = taken ? 1'b0 : (hold ? m_vd : 1'b1);
      end
      tick();
    end
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
